// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the main control decoder.
// Holds the PC and fetches one 32-bit word per request over a req/ack handshake.
// It presents the held word to decode and then steers the PC with the decoder's
// Jump/Branch outputs once decode consumes the word.

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    input  logic        instr_ack,

    input  logic        jump,
    input  logic        branch,
    input  logic        zero,

    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } fetchStateT;

    // The wait counter is 8 bits wide, so TIMEOUT is limited to 1..255.
    localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

    fetchStateT  state;
    fetchStateT  stateNext;

    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] instrNext;
    logic        reqNext;
    logic        validNext;
    logic [7:0]  waitCount;
    logic [7:0]  waitNext;
    logic [7:0]  waitInc;
    logic        errNext;

    logic [31:0] branchOffset;
    logic [31:0] jumpTarget;
    logic [31:0] branchTarget;
    logic [31:0] nextPc;

    // The address, opcode field and sequential PC are the only combinational outputs.
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = instr[31:26];

    // The sign-extended word offset is scaled to bytes.
    // Pseudo-direct jumps keep the top nibble of the sequential PC.
    assign branchOffset = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jumpTarget   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branchTarget = pc_plus4 + branchOffset;

    // The wait counter saturates so that a very long stall cannot wrap it back below TIMEOUT.
    assign waitInc = (waitCount == 8'hFF) ? waitCount : waitCount + 8'd1;

    // Next-PC selection for the held word: jump has priority over a taken branch.
    always_comb begin
        nextPc = pc_plus4;
        if (jump) begin
            nextPc = jumpTarget;
        end else if (branch && zero) begin
            nextPc = branchTarget;
        end
    end

    // Next-state logic and next values for every registered output and counter.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        instrNext = instr;
        reqNext   = 1'b0;
        validNext = 1'b0;
        waitNext  = waitCount;
        errNext   = fetch_err;

        unique case (state)
            IDLE: begin
                stateNext = REQ;
                reqNext   = 1'b1;
                waitNext  = 8'd0;
            end

            REQ: begin
                if (imem_ack) begin
                    instrNext = imem_rdata;
                    stateNext = HOLD;
                    validNext = 1'b1;
                    waitNext  = 8'd0;
                end else begin
                    reqNext  = 1'b1;
                    waitNext = waitInc;
                    if (waitInc >= TimeoutCount) begin
                        errNext = 1'b1;
                    end
                end
            end

            HOLD: begin
                validNext = 1'b1;
                if (instr_ack) begin
                    pcNext    = nextPc;
                    validNext = 1'b0;
                    reqNext   = 1'b1;
                    stateNext = REQ;
                    waitNext  = 8'd0;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // FSM state register. Reset abandons any outstanding request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath and output registers. The error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            waitCount   <= 8'd0;
            fetch_err   <= 1'b0;
        end else begin
            pc          <= pcNext;
            instr       <= instrNext;
            imem_req    <= reqNext;
            instr_valid <= validNext;
            waitCount   <= waitNext;
            fetch_err   <= errNext;
        end
    end

endmodule
